// File: rtl/mmio_pfvf_router.sv
// mmio_pfvf_router: table-driven MMIO router, one outstanding read with completion timeout.
// Optional event counters are compiled in with `define MMIO_ROUTER_STATS_EN.
module mmio_pfvf_router #(
    parameter int NUM_FUNCS   = 8,
    parameter int PF_W        = 3,
    parameter int VF_W        = 11,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 64,
    parameter int TAG_W       = 8,
    parameter int TIMEOUT_CYC = 256,
    parameter logic [NUM_FUNCS*PF_W-1:0] FUNC_PF =
        {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0},
    parameter logic [NUM_FUNCS*VF_W-1:0] FUNC_VF =
        {11'd0, 11'd0, 11'd0, 11'd0, 11'd2, 11'd1, 11'd0, 11'd0},
    parameter logic [NUM_FUNCS-1:0]      FUNC_VA = 8'b0000_1110
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [PF_W-1:0]             req_pf,
    input  logic [VF_W-1:0]             req_vf,
    input  logic                        req_va,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [TAG_W-1:0]            req_tag,
    output logic [NUM_FUNCS-1:0]        fn_req_valid,
    input  logic [NUM_FUNCS-1:0]        fn_req_ready,
    output logic                        fn_req_write,
    output logic [ADDR_W-1:0]           fn_req_addr,
    output logic [DATA_W-1:0]           fn_req_wdata,
    output logic [TAG_W-1:0]            fn_req_tag,
    input  logic [NUM_FUNCS-1:0]        fn_rsp_valid,
    input  logic [NUM_FUNCS*DATA_W-1:0] fn_rsp_data,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic                        rsp_err,
    output logic [15:0]                 stat_unmapped,
    output logic [15:0]                 stat_timeout
);

    localparam int IDX_W = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        RESPOND  = 2'd3
    } state_t;

    state_t               state_q;
    logic                 req_ready_q;
    logic [IDX_W-1:0]     idx_q;
    logic [TO_W-1:0]      to_cnt_q;
    logic [NUM_FUNCS-1:0] fn_req_valid_q;
    logic                 fn_req_write_q;
    logic [ADDR_W-1:0]    fn_req_addr_q;
    logic [DATA_W-1:0]    fn_req_wdata_q;
    logic [TAG_W-1:0]     fn_req_tag_q;
    logic                 rsp_valid_q;
    logic [DATA_W-1:0]    rsp_data_q;
    logic [TAG_W-1:0]     rsp_tag_q;
    logic                 rsp_err_q;

    logic [NUM_FUNCS-1:0] match_s;
    logic                 hit_s;
    logic [IDX_W-1:0]     hit_idx_s;
    logic [NUM_FUNCS-1:0] hit_oh_s;
    logic                 accept_s;
    logic                 rsp_hit_s;
    logic                 timeout_s;

    // Function table lookup; scanning downward lets the lowest matching entry win.
    always_comb begin
        match_s   = '0;
        hit_idx_s = '0;
        hit_oh_s  = '0;
        for (int i = 0; i < NUM_FUNCS; i++) begin
            match_s[i] = (req_pf == FUNC_PF[i*PF_W +: PF_W]) && (req_va == FUNC_VA[i]) &&
                         (!req_va || (req_vf == FUNC_VF[i*VF_W +: VF_W]));
        end
        for (int i = NUM_FUNCS - 1; i >= 0; i--) begin
            hit_idx_s = match_s[i] ? IDX_W'(i) : hit_idx_s;
        end
        hit_s              = |match_s;
        hit_oh_s[hit_idx_s] = hit_s;
    end

    assign accept_s  = req_valid && req_ready_q;
    assign rsp_hit_s = (state_q == WAIT_RSP) && fn_rsp_valid[idx_q];
    assign timeout_s = (state_q == WAIT_RSP) && !fn_rsp_valid[idx_q] && (to_cnt_q == TO_LAST);

    // Request/response FSM; every upstream and downstream output comes straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b0;
            idx_q          <= '0;
            to_cnt_q       <= '0;
            fn_req_valid_q <= '0;
            fn_req_write_q <= 1'b0;
            fn_req_addr_q  <= '0;
            fn_req_wdata_q <= '0;
            fn_req_tag_q   <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_tag_q      <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        fn_req_write_q <= req_write;
                        fn_req_addr_q  <= req_addr;
                        fn_req_wdata_q <= req_wdata;
                        fn_req_tag_q   <= req_tag;
                        if (hit_s) begin
                            state_q        <= ISSUE;
                            req_ready_q    <= 1'b0;
                            idx_q          <= hit_idx_s;
                            fn_req_valid_q <= hit_oh_s;
                        end else if (!req_write) begin
                            state_q     <= RESPOND;
                            req_ready_q <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '1;
                            rsp_tag_q   <= req_tag;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            req_ready_q <= 1'b1;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (fn_req_ready[idx_q]) begin
                        fn_req_valid_q <= '0;
                        to_cnt_q       <= '0;
                        if (fn_req_write_q) begin
                            state_q     <= IDLE;
                            req_ready_q <= 1'b1;
                        end else begin
                            state_q <= WAIT_RSP;
                        end
                    end else begin
                        fn_req_valid_q <= fn_req_valid_q;
                    end
                end
                WAIT_RSP: begin
                    // A response in the final timeout cycle still counts as a good completion.
                    if (rsp_hit_s) begin
                        state_q     <= RESPOND;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= fn_rsp_data[idx_q*DATA_W +: DATA_W];
                        rsp_tag_q   <= fn_req_tag_q;
                        rsp_err_q   <= 1'b0;
                    end else if (timeout_s) begin
                        state_q     <= RESPOND;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '1;
                        rsp_tag_q   <= fn_req_tag_q;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                RESPOND: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q        <= IDLE;
                    req_ready_q    <= 1'b0;
                    fn_req_valid_q <= '0;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign fn_req_valid = fn_req_valid_q;
    assign fn_req_write = fn_req_write_q;
    assign fn_req_addr  = fn_req_addr_q;
    assign fn_req_wdata = fn_req_wdata_q;
    assign fn_req_tag   = fn_req_tag_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_tag      = rsp_tag_q;
    assign rsp_err      = rsp_err_q;

`ifdef MMIO_ROUTER_STATS_EN
    logic [15:0] stat_unmapped_q;
    logic [15:0] stat_unmapped_d;
    logic [15:0] stat_timeout_q;
    logic [15:0] stat_timeout_d;
    logic        unmapped_s;

    assign unmapped_s = accept_s && !hit_s;

    // Saturating event counters.
    always_comb begin
        stat_unmapped_d = (unmapped_s && (stat_unmapped_q != 16'hFFFF)) ?
                          stat_unmapped_q + 16'd1 : stat_unmapped_q;
        stat_timeout_d  = (timeout_s && (stat_timeout_q != 16'hFFFF)) ?
                          stat_timeout_q + 16'd1 : stat_timeout_q;
    end

    // Counter state, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_unmapped_q <= 16'h0000;
            stat_timeout_q  <= 16'h0000;
        end else begin
            stat_unmapped_q <= stat_unmapped_d;
            stat_timeout_q  <= stat_timeout_d;
        end
    end

    assign stat_unmapped = stat_unmapped_q;
    assign stat_timeout  = stat_timeout_q;
`else
    assign stat_unmapped = 16'h0000;
    assign stat_timeout  = 16'h0000;
`endif

endmodule

// File: tb/tb_mmio_pfvf_router.sv
// Bench for mmio_pfvf_router: directed plan steps then randomized traffic against a table-level model.
module tb_mmio_pfvf_router;
    localparam int NF = 8, PF_W = 3, VF_W = 11, ADDR_W = 20, DATA_W = 64, TAG_W = 8, TO = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   req_valid, req_ready, req_write, req_va;
    logic [PF_W-1:0]        req_pf;
    logic [VF_W-1:0]        req_vf;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic [TAG_W-1:0]       req_tag;
    logic [NF-1:0]          fn_req_valid, fn_req_ready, fn_rsp_valid;
    logic                   fn_req_write;
    logic [ADDR_W-1:0]      fn_req_addr;
    logic [DATA_W-1:0]      fn_req_wdata;
    logic [TAG_W-1:0]       fn_req_tag;
    logic [NF*DATA_W-1:0]   fn_rsp_data;
    logic                   rsp_valid, rsp_err;
    logic [DATA_W-1:0]      rsp_data;
    logic [TAG_W-1:0]       rsp_tag;
    logic [15:0]            stat_unmapped, stat_timeout;

    mmio_pfvf_router #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_pf(req_pf), .req_vf(req_vf), .req_va(req_va),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .fn_req_valid(fn_req_valid), .fn_req_ready(fn_req_ready),
        .fn_req_write(fn_req_write), .fn_req_addr(fn_req_addr),
        .fn_req_wdata(fn_req_wdata), .fn_req_tag(fn_req_tag),
        .fn_rsp_valid(fn_rsp_valid), .fn_rsp_data(fn_rsp_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .stat_unmapped(stat_unmapped), .stat_timeout(stat_timeout)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0, fails = 0;
    int exp_unmapped = 0, exp_timeout = 0;
    int tbl_pf [NF] = '{0, 0, 0, 0, 1, 2, 3, 4};
    int tbl_vf [NF] = '{0, 0, 1, 2, 0, 0, 0, 0};
    bit tbl_va [NF] = '{0, 1, 1, 1, 0, 0, 0, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lowest-numbered table entry satisfying the decode rule, or -1.
    function automatic int lookup(input int pf, input int vf, input bit va);
        for (int i = 0; i < NF; i++)
            if (pf == tbl_pf[i] && va == tbl_va[i] && (!va || vf == tbl_vf[i])) return i;
        return -1;
    endfunction

    task automatic rnd_data();
        for (int i = 0; i < NF; i++) fn_rsp_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
    endtask

    task automatic chk_stats(input string tag);
`ifdef MMIO_ROUTER_STATS_EN
        chk({tag, "_stat_unm"}, stat_unmapped, 64'(exp_unmapped));
        chk({tag, "_stat_to"}, stat_timeout, 64'(exp_timeout));
`else
        chk({tag, "_stat_unm"}, stat_unmapped, 64'd0);
        chk({tag, "_stat_to"}, stat_timeout, 64'd0);
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 64'd0);
        chk({tag, "_fnv"}, fn_req_valid, 64'd0);
        chk({tag, "_fnw"}, fn_req_write, 64'd0);
        chk({tag, "_fna"}, fn_req_addr, 64'd0);
        chk({tag, "_fnd"}, fn_req_wdata, 64'd0);
        chk({tag, "_fnt"}, fn_req_tag, 64'd0);
        chk({tag, "_rv"}, rsp_valid, 64'd0);
        chk({tag, "_rd"}, rsp_data, 64'd0);
        chk({tag, "_rt"}, rsp_tag, 64'd0);
        chk({tag, "_re"}, rsp_err, 64'd0);
        chk({tag, "_su"}, stat_unmapped, 64'd0);
        chk({tag, "_st"}, stat_timeout, 64'd0);
    endtask

    // One full transaction from an idle negedge back to an idle negedge.
    // rsp_dly: wait-cycle index of the read response (<0 = never); rdy_dly: stall cycles before ready.
    task automatic xact(input bit wr, input int pf, input int vf, input bit va,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                        input logic [TAG_W-1:0] tag, input int rdy_dly, input int rsp_dly,
                        input logic [DATA_W-1:0] rdata, input bit late);
        int idx;
        logic [NF-1:0] oh;
        logic [DATA_W-1:0] exp_data;
        bit got;
        idx = lookup(pf, vf, va);
        chk("idle_ready", req_ready, 64'd1);
        req_valid = 1'b1; req_write = wr; req_pf = PF_W'(pf); req_vf = VF_W'(vf); req_va = va;
        req_addr = addr; req_wdata = wd; req_tag = tag;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_wdata = ~wd; req_tag = ~tag;
        if (idx < 0) begin
            exp_unmapped++;
            chk("unm_fnv", fn_req_valid, 64'd0);
            if (wr) begin
                chk("unm_wr_rsp", rsp_valid, 64'd0);
                chk("unm_wr_ready", req_ready, 64'd1);
            end else begin
                chk("unm_rd_rsp", rsp_valid, 64'd1);
                chk("unm_rd_data", rsp_data, {64{1'b1}});
                chk("unm_rd_err", rsp_err, 64'd1);
                chk("unm_rd_tag", rsp_tag, 64'(tag));
                chk("unm_rd_ready", req_ready, 64'd0);
                @(negedge clk);
                chk("unm_rd_pulse", rsp_valid, 64'd0);
                chk("unm_rd_ready2", req_ready, 64'd1);
            end
            return;
        end
        oh = NF'(1) << idx;
        for (int k = 0; k <= rdy_dly; k++) begin
            chk("iss_valid", fn_req_valid, 64'(oh));
            chk("iss_write", fn_req_write, 64'(wr));
            chk("iss_addr", fn_req_addr, 64'(addr));
            chk("iss_wdata", fn_req_wdata, wd);
            chk("iss_tag", fn_req_tag, 64'(tag));
            chk("iss_ready", req_ready, 64'd0);
            chk("iss_rsp", rsp_valid, 64'd0);
            fn_rsp_valid = NF'($urandom);
            fn_req_ready = (k == rdy_dly) ? (NF'($urandom) | oh) : (NF'($urandom) & ~oh);
            @(posedge clk); @(negedge clk);
        end
        fn_req_ready = '0; fn_rsp_valid = '0;
        chk("hs_drop", fn_req_valid, 64'd0);
        if (wr) begin
            chk("wr_ready", req_ready, 64'd1);
            chk("wr_norsp", rsp_valid, 64'd0);
            return;
        end
        chk("wt_ready", req_ready, 64'd0);
        got = 1'b0;
        exp_data = '1;
        for (int j = 0; j < TO; j++) begin
            chk("wt_norsp", rsp_valid, 64'd0);
            rnd_data();
            if (j == rsp_dly) begin
                fn_rsp_data[idx*DATA_W +: DATA_W] = rdata;
                fn_rsp_valid = NF'($urandom) | oh;
                exp_data = rdata;
                got = 1'b1;
            end else begin
                fn_rsp_valid = NF'($urandom) & ~oh;
            end
            @(posedge clk); @(negedge clk);
            fn_rsp_valid = '0;
            if (got) break;
        end
        if (!got) exp_timeout++;
        chk("rsp_valid", rsp_valid, 64'd1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, 64'(!got));
        chk("rsp_tag", rsp_tag, 64'(tag));
        chk("rsp_ready", req_ready, 64'd0);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 64'd0);
        chk("rsp_ready2", req_ready, 64'd1);
        if (late && !got) begin
            fn_rsp_valid = oh;
            @(posedge clk); @(negedge clk);
            fn_rsp_valid = '0;
            chk("late_ignored", rsp_valid, 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_pf = '0; req_vf = '0; req_va = 1'b0;
        req_addr = '0; req_wdata = '0; req_tag = '0;
        fn_req_ready = '0; fn_rsp_valid = '0; fn_rsp_data = '0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        chk("rel_ready_low", req_ready, 64'd0);
        @(negedge clk);
        chk("ready_rise", req_ready, 64'd1);

        // Mapped PF2 read to HE-LB, best case then one-cycle delayed response.
        xact(1'b0, 2, 0, 1'b0, 20'h00100, 64'h0, 8'h5A, 0, 0, 64'hDEADBEEF_00000001, 1'b0);
        xact(1'b0, 2, 0, 1'b0, 20'h00100, 64'h0, 8'h5B, 0, 1, 64'hDEADBEEF_00000001, 1'b0);
        // PF access ignores VF number.
        xact(1'b0, 2, 77, 1'b0, 20'h00200, 64'h0, 8'h21, 1, 2, 64'h0123_4567_89AB_CDEF, 1'b0);
        // VF decode: write to entry 2, then unmapped VF read.
        xact(1'b1, 0, 1, 1'b1, 20'h00018, 64'h1234, 8'h30, 0, -1, 64'h0, 1'b0);
        xact(1'b0, 0, 5, 1'b1, 20'h00018, 64'h0, 8'h31, 0, -1, 64'h0, 1'b0);
        chk_stats("vfdec");
        // Timeout with a late response, then response on the last count cycle.
        xact(1'b0, 3, 0, 1'b0, 20'h00040, 64'h0, 8'h40, 0, -1, 64'h0, 1'b1);
        chk_stats("timeout");
        xact(1'b0, 3, 0, 1'b0, 20'h00048, 64'h0, 8'h41, 0, TO - 1, 64'hCAFE_F00D_0000_0015, 1'b0);
        chk_stats("collide");
        // Backpressured PF1 write, then back-to-back writes.
        xact(1'b1, 1, 0, 1'b0, 20'h00080, 64'hA5A5_0000_1111_2222, 8'h50, 10, -1, 64'h0, 1'b0);
        xact(1'b1, 4, 0, 1'b0, 20'h00088, 64'h77, 8'h51, 0, -1, 64'h0, 1'b0);
        xact(1'b1, 0, 9, 1'b0, 20'h00090, 64'h78, 8'h52, 0, -1, 64'h0, 1'b0);
        chk_stats("bp");

        // Reset while waiting for a read response.
        req_valid = 1'b1; req_write = 1'b0; req_pf = 3'd2; req_vf = '0; req_va = 1'b0;
        req_addr = 20'h00300; req_tag = 8'h60;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        chk("mr_issue", fn_req_valid, 64'h20);
        fn_req_ready = 8'h20;
        @(posedge clk); @(negedge clk);
        fn_req_ready = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        fn_rsp_valid = 8'h20;
        @(negedge clk);
        fn_rsp_valid = '0;
        chk("midrst_norsp", rsp_valid, 64'd0);
        rst_n = 1'b1;
        exp_unmapped = 0; exp_timeout = 0;
        @(negedge clk);
        chk("midrst_norsp2", rsp_valid, 64'd0);
        chk("midrst_ready", req_ready, 64'd1);
        chk_stats("midrst");
        xact(1'b0, 2, 0, 1'b0, 20'h00300, 64'h0, 8'h61, 0, 0, 64'h1111_2222_3333_4444, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int pf, vf, rd, rdly;
            bit va;
            pf = $urandom_range(0, 5);
            va = (pf == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            vf = ($urandom_range(0, 7) == 0) ? 2047 : $urandom_range(0, 3);
            rd = $urandom_range(0, 9);
            rdly = (rd < 6) ? $urandom_range(0, 4) : (rd < 8) ? (TO - 1 - (rd - 6)) : -1;
            xact(1'($urandom_range(0, 1)), pf, vf, va, ADDR_W'($urandom), {$urandom, $urandom},
                 TAG_W'($urandom), $urandom_range(0, 3), rdly, {$urandom, $urandom},
                 1'($urandom_range(0, 1)));
        end
        chk_stats("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
